// File: rtl/npu_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// npu_seq_pkg : shared types and default sizes for npu_input_sequencer
// Revision    : 1.0
// ----------------------------------------------------------------------------
package npu_seq_pkg;

  localparam int SEQ_DATA_W    = 32;
  localparam int SEQ_CONF_W    = 16;
  localparam int SEQ_CFG_DEPTH = 4;
  localparam int SEQ_CNT_W     = 16;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SEQ_CFG_AW = addr_w(SEQ_CFG_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/npu_input_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// npu_input_sequencer_if : host, PE and input-interface signals of the sequencer
// Revision               : 1.0
// ----------------------------------------------------------------------------
interface npu_input_sequencer_if
  import npu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int CONF_W = SEQ_CONF_W,
  parameter int CNT_W  = SEQ_CNT_W,
  parameter int CFG_AW = SEQ_CFG_AW
) ();

  logic              seq_cfg_wr_en;
  logic [CFG_AW-1:0] seq_cfg_wr_addr;
  logic [CONF_W-1:0] seq_cfg_wr_data;
  logic              seq_start;
  logic [CNT_W-1:0]  seq_num_words;
  logic              host_data_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_data_ready;
  logic              pe_ready;
  logic              pe_valid;
  logic              npu_input_fifo_full;
  logic              npu_input_fifo_empty;
  logic              npu_input_interface_conf_data_en;
  logic [CONF_W-1:0] npu_input_interface_conf_data;
  logic              npu_input_fifo_write_en;
  logic [DATA_W-1:0] npu_input_data;
  logic              npu_input_fifo_read_en;
  logic              seq_busy;
  logic              seq_done;

  // Environment side: host/DMA, PE array and the input interface flags.
  modport master (
    output seq_cfg_wr_en, seq_cfg_wr_addr, seq_cfg_wr_data,
    output seq_start, seq_num_words,
    output host_data_valid, host_data, pe_ready,
    output npu_input_fifo_full, npu_input_fifo_empty,
    input  host_data_ready, pe_valid,
    input  npu_input_interface_conf_data_en, npu_input_interface_conf_data,
    input  npu_input_fifo_write_en, npu_input_data, npu_input_fifo_read_en,
    input  seq_busy, seq_done
  );

  modport slave (
    input  seq_cfg_wr_en, seq_cfg_wr_addr, seq_cfg_wr_data,
    input  seq_start, seq_num_words,
    input  host_data_valid, host_data, pe_ready,
    input  npu_input_fifo_full, npu_input_fifo_empty,
    output host_data_ready, pe_valid,
    output npu_input_interface_conf_data_en, npu_input_interface_conf_data,
    output npu_input_fifo_write_en, npu_input_data, npu_input_fifo_read_en,
    output seq_busy, seq_done
  );

endinterface
`default_nettype wire

// File: rtl/npu_seq_cfg_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// npu_seq_cfg_regfile : configuration word store, sync write/clear, async read
// Revision            : 1.0
// ----------------------------------------------------------------------------
module npu_seq_cfg_regfile
  import npu_seq_pkg::*;
#(
  parameter int CFG_DEPTH = SEQ_CFG_DEPTH,
  parameter int CONF_W    = SEQ_CONF_W,
  parameter int CFG_AW    = addr_w(CFG_DEPTH)
) (
  input  logic              CLK,
  input  logic              npu_rst,
  input  logic              wr_en,
  input  logic [CFG_AW-1:0] wr_addr,
  input  logic [CONF_W-1:0] wr_data,
  input  logic [CFG_AW-1:0] rd_addr,
  output logic [CONF_W-1:0] rd_data
);

  logic [CONF_W-1:0] mem [CFG_DEPTH];

  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      for (int i = 0; i < CFG_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (int'(wr_addr) < CFG_DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_addr) < CFG_DEPTH) ? mem[rd_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/npu_input_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// npu_input_sequencer : loads config words, then streams a job through the
//                       npu_input_interface FIFO (32-bit in, 16-bit out)
// Revision            : 1.0
// ----------------------------------------------------------------------------
module npu_input_sequencer
  import npu_seq_pkg::*;
#(
  parameter int DATA_W    = SEQ_DATA_W,
  parameter int CONF_W    = SEQ_CONF_W,
  parameter int CFG_DEPTH = SEQ_CFG_DEPTH,
  parameter int CNT_W     = SEQ_CNT_W
) (
  input  logic                 CLK,
  input  logic                 npu_rst,
  npu_input_sequencer_if.slave bus
);

  localparam int CFG_AW = addr_w(CFG_DEPTH);

  seq_state_t        state;
  logic [CFG_AW-1:0] idx;
  logic [CNT_W-1:0]  wr_target;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W:0]    rd_target;
  logic [CNT_W:0]    rd_cnt;
  logic              conf_en_r;
  logic [CONF_W-1:0] conf_data_r;
  logic              pe_valid_r;
  logic              done_r;

  logic              in_stream;
  logic              host_ready;
  logic              write_en;
  logic              read_en;
  logic              idx_last;
  logic [CFG_AW-1:0] rf_rd_addr;
  logic [CONF_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] wdata;

  assign in_stream  = (state == STREAM);
  assign host_ready = in_stream && (wr_cnt < wr_target) && !bus.npu_input_fifo_full;
  assign write_en   = bus.host_data_valid && host_ready;
  assign read_en    = in_stream && bus.pe_ready && !bus.npu_input_fifo_empty
                      && (rd_cnt < rd_target);
  assign idx_last   = (idx == CFG_AW'(CFG_DEPTH - 1));
  assign wdata      = in_stream ? bus.host_data : '0;

  // Lookahead: the registered conf_data must already hold the next word.
  assign rf_rd_addr = (state == CONFIG) ? idx + CFG_AW'(1) : '0;

  npu_seq_cfg_regfile #(
    .CFG_DEPTH (CFG_DEPTH),
    .CONF_W    (CONF_W),
    .CFG_AW    (CFG_AW)
  ) u_regfile (
    .CLK     (CLK),
    .npu_rst (npu_rst),
    .wr_en   (bus.seq_cfg_wr_en && (state == IDLE)),
    .wr_addr (bus.seq_cfg_wr_addr),
    .wr_data (bus.seq_cfg_wr_data),
    .rd_addr (rf_rd_addr),
    .rd_data (rf_rd_data)
  );

  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      state       <= IDLE;
      idx         <= '0;
      wr_target   <= '0;
      wr_cnt      <= '0;
      rd_target   <= '0;
      rd_cnt      <= '0;
      conf_en_r   <= 1'b0;
      conf_data_r <= '0;
      pe_valid_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      pe_valid_r <= read_en;
      done_r     <= 1'b0;
      conf_en_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.seq_start) begin
            if (bus.seq_num_words != '0) begin
              wr_target   <= bus.seq_num_words;
              rd_target   <= {bus.seq_num_words, 1'b0};
              idx         <= '0;
              wr_cnt      <= '0;
              rd_cnt      <= '0;
              conf_en_r   <= 1'b1;
              conf_data_r <= rf_rd_data;
              state       <= CONFIG;
            end else begin
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        CONFIG: begin
          if (idx_last) begin
            state <= STREAM;
          end else begin
            conf_en_r   <= 1'b1;
            conf_data_r <= rf_rd_data;
            idx         <= idx + CFG_AW'(1);
          end
        end
        STREAM: begin
          if (write_en) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
          end
          if (read_en) begin
            rd_cnt <= rd_cnt + (CNT_W+1)'(1);
            if (rd_cnt + (CNT_W+1)'(1) == rd_target) begin
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.host_data_ready                  = host_ready;
  assign bus.npu_input_fifo_write_en          = write_en;
  assign bus.npu_input_data                   = wdata;
  assign bus.npu_input_fifo_read_en           = read_en;
  assign bus.pe_valid                         = pe_valid_r;
  assign bus.npu_input_interface_conf_data_en = conf_en_r;
  assign bus.npu_input_interface_conf_data    = conf_data_r;
  assign bus.seq_busy                         = (state == CONFIG) || (state == STREAM);
  assign bus.seq_done                         = done_r;

endmodule
`default_nettype wire
